// File: rtl/screen_scanner.sv
// Raster scanner for the 512x256 memory-mapped screen: generates sync timing,
// prefetches one screen word per 16 pixels on the RAM read port and shifts
// pixels out LSB-first.
module screen_scanner #(
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned H_SYNC  = 64,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned V_FRONT = 4,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        scr_rd,
  output logic [12:0] scr_addr,
  input  logic [15:0] scr_data,
  output logic        pixel,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned H_ACTIVE = 512;
  localparam int unsigned V_ACTIVE = 256;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_BEG   = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG   = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_BEG + V_SYNC;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0]    state, state_nx;
  logic [HW-1:0] h, h_nx;
  logic [VW-1:0] v, v_nx, v_after;
  logic          h_last, v_last;
  logic          line_fetch, wrap_fetch, fetch_c;
  logic [12:0]   fetch_addr_c;
  logic [4:0]    fetch_col;
  logic          running, active, load, pix_src;
  logic [15:0]   shifter, shifter_nx, word_q;
  logic          rd_d;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  // State and raster counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_STOPPED;
      h     <= '0;
      v     <= VW'(V_ACTIVE);
    end else begin
      state <= state_nx;
      h     <= h_nx;
      v     <= v_nx;
    end
  end

  // Next state and counter advance; DRAIN finishes the frame before stopping
  always_comb begin
    state_nx = state;
    h_nx     = h;
    v_nx     = v;
    case (state)
      ST_STOPPED: begin
        h_nx = '0;
        v_nx = VW'(V_ACTIVE);
        if (enable) state_nx = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (h_last) begin
          h_nx = '0;
          v_nx = v_last ? '0 : v + VW'(1);
        end else begin
          h_nx = h + HW'(1);
        end
        if (state == ST_RUN && !enable) begin
          state_nx = ST_DRAIN;
        end else if (state == ST_DRAIN && enable) begin
          state_nx = ST_RUN;
        end else if (state == ST_DRAIN && h_last && v_last) begin
          state_nx = ST_STOPPED;
          h_nx     = '0;
          v_nx     = VW'(V_ACTIVE);
        end
      end
      default: begin
        state_nx = ST_STOPPED;
        h_nx     = '0;
        v_nx     = VW'(V_ACTIVE);
      end
    endcase
  end

  // Fetch decision for the next counter position so the strobe register lines up with it
  always_comb begin
    v_after      = (v_nx == VW'(V_TOTAL - 1)) ? '0 : v_nx + VW'(1);
    fetch_col    = 5'((h_nx + HW'(2)) >> 4);
    line_fetch   = (v_nx < VW'(V_ACTIVE)) && (h_nx[3:0] == 4'hE) &&
                   (h_nx < HW'(H_ACTIVE - 16));
    wrap_fetch   = (h_nx == HW'(H_TOTAL - 2)) && (v_after < VW'(V_ACTIVE));
    fetch_c      = (state_nx != ST_STOPPED) && (line_fetch || wrap_fetch);
    fetch_addr_c = wrap_fetch ? {v_after[7:0], 5'd0} : {v_nx[7:0], fetch_col};
  end

  // Pixel source: fresh word at each 16-column boundary, otherwise the shifter
  always_comb begin
    running    = (state != ST_STOPPED);
    active     = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    load       = active && (h[3:0] == 4'h0);
    pix_src    = load ? word_q[0] : shifter[0];
    shifter_nx = load ? {1'b0, word_q[15:1]} : {1'b0, shifter[15:1]};
  end

  // Screen RAM read port and returned-word capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      scr_rd   <= 1'b0;
      scr_addr <= '0;
      rd_d     <= 1'b0;
      word_q   <= '0;
    end else begin
      scr_rd <= fetch_c;
      if (fetch_c) scr_addr <= fetch_addr_c;
      rd_d <= scr_rd;
      if (rd_d) word_q <= scr_data;
    end
  end

  // Video outputs, one clock behind the counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      shifter     <= '0;
      pixel       <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shifter     <= shifter_nx;
      pixel       <= running && active && pix_src;
      hsync_n     <= !(running && (32'(h) >= HS_BEG) && (32'(h) < HS_END));
      vsync_n     <= !(running && (32'(v) >= VS_BEG) && (32'(v) < VS_END));
      frame_start <= running && (h == '0) && (v == '0);
      busy        <= (state_nx != ST_STOPPED);
    end
  end

endmodule
